// File: rtl/complex_window_sum_if.sv
`default_nettype none
// ============================================================================
//  Module      : complex_window_sum_if
//  Description : Sample-in / windowed-sum-out bundle for complex_window_sum.
//                master = sample producer and sum consumer, slave = the window.
//  Revision    : 1.0  initial release
// ============================================================================
interface complex_window_sum_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int WINDOW_LOG2 = 4
);
    logic                                      enable;
    logic signed [DATA_WIDTH-1:0]              data_i;
    logic signed [DATA_WIDTH-1:0]              data_q;
    logic                                      input_strobe;
    logic signed [DATA_WIDTH+WINDOW_LOG2-1:0]  sum_i;
    logic signed [DATA_WIDTH+WINDOW_LOG2-1:0]  sum_q;
    logic                                      output_strobe;
    logic                                      window_full;

    modport master (
        output enable, data_i, data_q, input_strobe,
        input  sum_i, sum_q, output_strobe, window_full
    );

    modport slave (
        input  enable, data_i, data_q, input_strobe,
        output sum_i, sum_q, output_strobe, window_full
    );
endinterface
`default_nettype wire

// File: rtl/complex_window_sum.sv
`default_nettype none
// ============================================================================
//  Module      : complex_window_sum
//  Description : Sliding-window complex accumulator. Keeps the running sum of
//                the last 2^WINDOW_LOG2 accepted I/Q samples using a circular
//                buffer; each accepted sample adds itself and removes the
//                sample it overwrites. Two-cycle latency, one sample/cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module complex_window_sum #(
    parameter int DATA_WIDTH  = 32,
    parameter int WINDOW_LOG2 = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    complex_window_sum_if.slave   bus
);
    localparam int SUM_WIDTH = DATA_WIDTH + WINDOW_LOG2;
    localparam int c_depth   = 1 << WINDOW_LOG2;
    localparam logic [WINDOW_LOG2:0] c_fill_max  = (WINDOW_LOG2+1)'(c_depth);
    localparam logic [WINDOW_LOG2:0] c_fill_last = (WINDOW_LOG2+1)'(c_depth - 1);

    // Sample storage, {I,Q} per slot. Not reset: fill masking hides stale slots.
    logic [2*DATA_WIDTH-1:0]        r_mem [c_depth];

    // Stage 0 control
    logic [WINDOW_LOG2-1:0]         r_wr_ptr;
    logic [WINDOW_LOG2:0]           r_fill;

    // Stage 1 registers
    logic                           r_s1_valid;
    logic                           r_s1_full;
    logic signed [DATA_WIDTH-1:0]   r_s1_new_i;
    logic signed [DATA_WIDTH-1:0]   r_s1_new_q;
    logic signed [DATA_WIDTH-1:0]   r_s1_old_i;
    logic signed [DATA_WIDTH-1:0]   r_s1_old_q;

    // Stage 2 registers (outputs)
    logic signed [SUM_WIDTH-1:0]    r_sum_i;
    logic signed [SUM_WIDTH-1:0]    r_sum_q;
    logic                           r_out_strobe;
    logic                           r_window_full;

    logic                           w_accept;
    logic                           w_was_full;
    logic [2*DATA_WIDTH-1:0]        w_rd_data;

    assign w_accept   = bus.enable && bus.input_strobe;
    assign w_was_full = (r_fill == c_fill_max);
    // Read-before-write: the slot about to be overwritten holds the oldest sample.
    assign w_rd_data  = r_mem[r_wr_ptr];

    // Write the accepted sample into the current slot; a reset cycle writes nothing.
    always_ff @(posedge clock) begin
        if (w_accept && !reset) begin
            r_mem[r_wr_ptr] <= {bus.data_i, bus.data_q};
        end
    end

    // Advance pointer/fill count and capture new + oldest sample into stage 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_full  <= 1'b0;
            r_s1_new_i <= '0;
            r_s1_new_q <= '0;
            r_s1_old_i <= '0;
            r_s1_old_q <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                if (!w_was_full) begin
                    r_fill <= r_fill + 1'b1;
                end
                r_s1_new_i <= bus.data_i;
                r_s1_new_q <= bus.data_q;
                // Until the window has filled once, the slot being replaced was
                // never written since reset, so it must contribute nothing.
                r_s1_old_i <= w_was_full ? w_rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
                r_s1_old_q <= w_was_full ? w_rd_data[DATA_WIDTH-1:0]            : '0;
                // This sample completes the window if N-1 came before it.
                r_s1_full  <= (r_fill >= c_fill_last);
            end
        end
    end

    // Update running sums (add newest, drop oldest) and pulse the output strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sum_i       <= '0;
            r_sum_q       <= '0;
            r_out_strobe  <= 1'b0;
            r_window_full <= 1'b0;
        end else begin
            r_out_strobe <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum_i <= r_sum_i + SUM_WIDTH'(r_s1_new_i) - SUM_WIDTH'(r_s1_old_i);
                r_sum_q <= r_sum_q + SUM_WIDTH'(r_s1_new_q) - SUM_WIDTH'(r_s1_old_q);
                if (r_s1_full) begin
                    r_window_full <= 1'b1;
                end
            end
        end
    end

    assign bus.sum_i         = r_sum_i;
    assign bus.sum_q         = r_sum_q;
    assign bus.output_strobe = r_out_strobe;
    assign bus.window_full   = r_window_full;

endmodule
`default_nettype wire

// File: tb/tb_complex_window_sum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_complex_window_sum
//  Description : Self-checking bench for complex_window_sum. A queue-based
//                window model produces the expected sums; expected results
//                are scheduled two cycles after each accepted sample.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_complex_window_sum;
    localparam int DW = 32;
    localparam int WL = 4;
    localparam int N  = 1 << WL;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    complex_window_sum_if #(.DATA_WIDTH(DW), .WINDOW_LOG2(WL)) bus ();

    complex_window_sum #(.DATA_WIDTH(DW), .WINDOW_LOG2(WL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int     due;
        longint si;
        longint sq;
        bit     full;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    int     n_acc = 0;
    bit     chk_en = 1'b0;
    longint win_i[$];
    longint win_q[$];
    exp_t   pend[$];
    longint exp_si   = 0;
    longint exp_sq   = 0;
    bit     exp_full = 1'b0;

    task automatic check_value(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, update the model, check outputs mid-cycle.
    task automatic step(input bit en, input bit stb, input bit rst,
                        input logic [31:0] di, input logic [31:0] dq);
        exp_t   e;
        bit     due;
        reset            = rst;
        bus.enable       = en;
        bus.input_strobe = stb;
        bus.data_i       = di;
        bus.data_q       = dq;
        if (en && stb && !rst) begin
            win_i.push_back(longint'($signed(di)));
            win_q.push_back(longint'($signed(dq)));
            if (win_i.size() > N) begin
                void'(win_i.pop_front());
                void'(win_q.pop_front());
            end
            n_acc++;
            e.si = 0;
            e.sq = 0;
            foreach (win_i[k]) begin
                e.si += win_i[k];
                e.sq += win_q[k];
            end
            e.full = (n_acc >= N);
            e.due  = cyc + 2;
            pend.push_back(e);
        end
        @(negedge clock);
        if (chk_en) begin
            due = (pend.size() > 0) && (pend[0].due == cyc);
            if (due) begin
                e        = pend.pop_front();
                exp_si   = e.si;
                exp_sq   = e.sq;
                exp_full = exp_full | e.full;
            end
            check_value("output_strobe", longint'(bus.output_strobe), longint'(due));
            check_value("sum_i", longint'($signed(bus.sum_i)), exp_si);
            check_value("sum_q", longint'($signed(bus.sum_q)), exp_sq);
            check_value("window_full", longint'(bus.window_full), longint'(exp_full));
        end
        if (rst) begin
            win_i.delete();
            win_q.delete();
            pend.delete();
            n_acc    = 0;
            exp_si   = 0;
            exp_sq   = 0;
            exp_full = 1'b0;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] rd_i;
        logic [31:0] rd_q;
        bit          ren;
        bit          rstb;
        bit          rrst;

        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.input_strobe = 1'b0;
        bus.data_i       = '0;
        bus.data_q       = '0;
        @(posedge clock);
        #1;
        step(1'b0, 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b0, 1'b1, '0, '0);
        chk_en = 1'b1;

        // Reset state
        check_value("rst_sum_i", longint'($signed(bus.sum_i)), 0);
        check_value("rst_sum_q", longint'($signed(bus.sum_q)), 0);
        check_value("rst_strobe", longint'(bus.output_strobe), 0);
        check_value("rst_full", longint'(bus.window_full), 0);
        idle(2);

        // Constant 100 / -3, twenty back-to-back
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'd100, -32'sd3);
        idle(4);
        check_value("const_hold_i", longint'($signed(bus.sum_i)), 1600);
        check_value("const_hold_q", longint'($signed(bus.sum_q)), -48);
        check_value("const_full", longint'(bus.window_full), 1);
        step(1'b0, 1'b0, 1'b1, '0, '0);

        // Impulse
        step(1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
        repeat (30) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(3);
        check_value("impulse_end_i", longint'($signed(bus.sum_i)), 0);
        step(1'b0, 1'b0, 1'b1, '0, '0);

        // Extremes
        repeat (16) step(1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
        idle(2);
        check_value("extreme_i", longint'($signed(bus.sum_i)), 64'sd34359738352);
        check_value("extreme_q", longint'($signed(bus.sum_q)), -64'sd34359738368);
        repeat (16) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        idle(2);
        check_value("extreme_back_i", longint'($signed(bus.sum_i)), 0);
        check_value("extreme_back_q", longint'($signed(bus.sum_q)), 0);
        step(1'b0, 1'b0, 1'b1, '0, '0);

        // Latency with gaps: strobes at relative cycles 0, 1, 5
        for (int k = 0; k < 10; k++)
            step(1'b1, (k == 0) || (k == 1) || (k == 5), 1'b0, $urandom, $urandom);

        // Strobes while disabled, then re-enable
        repeat (5) step(1'b0, 1'b1, 1'b0, $urandom, $urandom);
        repeat (4) step(1'b1, 1'b1, 1'b0, $urandom, $urandom);
        idle(3);
        step(1'b0, 1'b0, 1'b1, '0, '0);

        // Ramp 1..8 with reset the cycle after the 8th strobe
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, 1'b0, k, k);
        step(1'b0, 1'b1, 1'b1, 32'd99, 32'd99);
        idle(3);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'd1, 32'd1);
        idle(2);
        check_value("post_reset_i", longint'($signed(bus.sum_i)), 3);
        check_value("post_reset_q", longint'($signed(bus.sum_q)), 3);

        // Random traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            ren  = ($urandom % 4) != 0;
            rstb = ($urandom % 3) != 0;
            rrst = ($urandom % 97) == 0;
            case ($urandom % 6)
                0:       begin rd_i = 32'h7FFF_FFFF; rd_q = 32'h8000_0000; end
                1:       begin rd_i = 32'h8000_0000; rd_q = 32'h7FFF_FFFF; end
                default: begin rd_i = $urandom;      rd_q = $urandom;      end
            endcase
            step(ren, rstb, rrst, rd_i, rd_q);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
